// File: rtl/ifetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage:
// address/instruction widths, boolean aliases, FSM encoding and
// helpers that derive instruction-cache index/tag bit ranges from IDX_W.
package ifetch_unit_pkg;

  // Address and instruction word widths (ADDR / INSTRLEN ranges).
  localparam int ADDR_W    = 32;
  localparam int INSTR_W   = 32;

  // Boolean aliases and the all-zero word.
  localparam logic                TRUE   = 1'b1;
  localparam logic                FALSE  = 1'b0;
  localparam logic [ADDR_W-1:0]   NULL32 = '0;

  // Byte offset within a word; the cache index starts right above it.
  localparam int WORD_OFF_W = 2;

  // Fetch FSM: either ready to look up the PC, or waiting on memory.
  typedef enum logic {
    S_IDLE     = 1'b0,
    S_WAIT_MEM = 1'b1
  } fetch_state_t;

  // Lowest/highest bit of the cache index within a byte address.
  function automatic int icache_idx_lo();
    return WORD_OFF_W;
  endfunction

  function automatic int icache_idx_hi(input int idx_w);
    return idx_w + WORD_OFF_W - 1;
  endfunction

  // Lowest bit of the cache tag and its width within a byte address.
  function automatic int icache_tag_lo(input int idx_w);
    return idx_w + WORD_OFF_W;
  endfunction

  function automatic int icache_tag_w(input int idx_w);
    return ADDR_W - idx_w - WORD_OFF_W;
  endfunction

endpackage

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache, one 32-bit word per line.
// Combinational lookup port (word address -> hit, data) and a synchronous
// write port. Valid bits clear asynchronously on rst; tag/data do not.
module icache_dm
  import ifetch_unit_pkg::*;
#(
  parameter int LINES = 64,
  parameter int IDX_W = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  // Lookup port, word address (byte offset stripped)
  input  logic [ADDR_W-1:WORD_OFF_W]    i_rd_addr,
  output logic                          o_hit,
  output logic [INSTR_W-1:0]            o_rd_data,
  // Fill port, word address
  input  logic                          i_we,
  input  logic [ADDR_W-1:WORD_OFF_W]    i_wr_addr,
  input  logic [INSTR_W-1:0]            i_wr_data
);

  localparam int IDX_LO = icache_idx_lo();
  localparam int IDX_HI = icache_idx_hi(IDX_W);
  localparam int TAG_LO = icache_tag_lo(IDX_W);
  localparam int TAG_W  = icache_tag_w(IDX_W);

  logic [LINES-1:0]   r_valid;
  logic [TAG_W-1:0]   r_tag  [LINES];
  logic [INSTR_W-1:0] r_data [LINES];

  logic [IDX_W-1:0]   w_rd_idx;
  logic [TAG_W-1:0]   w_rd_tag;
  logic [IDX_W-1:0]   w_wr_idx;
  logic [TAG_W-1:0]   w_wr_tag;

  assign w_rd_idx = i_rd_addr[IDX_HI:IDX_LO];
  assign w_rd_tag = i_rd_addr[ADDR_W-1:TAG_LO];
  assign w_wr_idx = i_wr_addr[IDX_HI:IDX_LO];
  assign w_wr_tag = i_wr_addr[ADDR_W-1:TAG_LO];

  // Valid bits: cleared on reset, set when a line is filled.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values and simulation matches the synthesized registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[w_wr_idx] <= TRUE;
    end
  end

  // Tag and data arrays: written on fill only.
  // NOTE: these arrays are deliberately not reset; the valid bits gate every
  // lookup, so stale contents are never visible and the arrays can map to RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[w_wr_idx]  <= w_wr_tag;
      r_data[w_wr_idx] <= i_wr_data;
    end
  end

  assign o_hit     = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
  assign o_rd_data = r_data[w_rd_idx];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, a direct-mapped I-cache and the
// miss FSM. Issues one instruction per cycle to the decoder on a hit,
// fetches missing words from the memory controller, stalls on a full
// backend and redirects on a ROB misprediction. All outputs are registered.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter int               ICACHE_LINES = 64,
  parameter int               IDX_W        = 6,
  parameter logic [31:0]      RESET_PC     = 32'h0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                stall,
  input  logic                jump_wrong,
  input  logic [ADDR_W-1:0]   jump_pc,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_done,
  input  logic [INSTR_W-1:0]  mem_instr,
  output logic                IF_success,
  output logic [INSTR_W-1:0]  instr,
  output logic [ADDR_W-1:0]   fetch_pc
);

  // Architectural state and registered outputs
  fetch_state_t         r_state;
  logic [ADDR_W-1:0]    r_pc;
  logic                 r_if_success;
  logic [INSTR_W-1:0]   r_instr;
  logic [ADDR_W-1:0]    r_fetch_pc;
  logic                 r_mem_req;
  logic [ADDR_W-1:0]    r_mem_addr;

  // Next-state values
  fetch_state_t         w_state_nxt;
  logic [ADDR_W-1:0]    w_pc_nxt;
  logic                 w_if_success_nxt;
  logic [INSTR_W-1:0]   w_instr_nxt;
  logic [ADDR_W-1:0]    w_fetch_pc_nxt;
  logic                 w_mem_req_nxt;
  logic [ADDR_W-1:0]    w_mem_addr_nxt;

  // Cache interface
  logic                 w_hit;
  logic [INSTR_W-1:0]   w_line_data;
  logic                 w_cache_we;
  logic                 w_fill;

  // A fill happens whenever memory answers an outstanding request, even if
  // a redirect lands in the same cycle: the address is still valid.
  assign w_fill     = (r_state == S_WAIT_MEM) && mem_done;
  assign w_cache_we = rdy && w_fill;

  icache_dm #(
    .LINES (ICACHE_LINES),
    .IDX_W (IDX_W)
  ) u_icache (
    .clk       (clk),
    .rst       (rst),
    .i_rd_addr (r_pc[ADDR_W-1:WORD_OFF_W]),
    .o_hit     (w_hit),
    .o_rd_data (w_line_data),
    .i_we      (w_cache_we),
    .i_wr_addr (r_mem_addr[ADDR_W-1:WORD_OFF_W]),
    .i_wr_data (mem_instr)
  );

  // State register for the fetch FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: redirect wins, otherwise miss -> WAIT_MEM -> IDLE.
  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    if (rdy) begin
      if (jump_wrong) begin
        w_state_nxt = S_IDLE;
      end else begin
        unique case (r_state)
          S_IDLE:     if (!w_hit)   w_state_nxt = S_WAIT_MEM;
          S_WAIT_MEM: if (mem_done) w_state_nxt = S_IDLE;
          default:                  w_state_nxt = S_IDLE;
        endcase
      end
    end
  end

  // Output/datapath logic: PC advance, issue, and memory request control.
  // With rdy low everything holds except the issue pulse, which drops.
  always_comb begin
    w_pc_nxt         = r_pc;
    w_if_success_nxt = FALSE;
    w_instr_nxt      = r_instr;
    w_fetch_pc_nxt   = r_fetch_pc;
    w_mem_req_nxt    = r_mem_req;
    w_mem_addr_nxt   = r_mem_addr;
    if (rdy) begin
      if (jump_wrong) begin
        // Abandon any outstanding request; old-path words never issue.
        w_pc_nxt      = jump_pc;
        w_mem_req_nxt = FALSE;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (w_hit) begin
              if (!stall) begin
                w_if_success_nxt = TRUE;
                w_instr_nxt      = w_line_data;
                w_fetch_pc_nxt   = r_pc;
                w_pc_nxt         = r_pc + 32'd4;
              end
            end else begin
              // Misses are serviced even while the backend is full.
              w_mem_req_nxt  = TRUE;
              w_mem_addr_nxt = {r_pc[ADDR_W-1:WORD_OFF_W], 2'b00};
            end
          end
          S_WAIT_MEM: begin
            // Request stays stable until the controller answers; the word
            // then issues next cycle through the normal hit path.
            if (mem_done) w_mem_req_nxt = FALSE;
          end
          default: w_mem_req_nxt = FALSE;
        endcase
      end
    end
  end

  // PC and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_if_success <= FALSE;
      r_instr      <= NULL32;
      r_fetch_pc   <= NULL32;
      r_mem_req    <= FALSE;
      r_mem_addr   <= NULL32;
    end else begin
      r_pc         <= w_pc_nxt;
      r_if_success <= w_if_success_nxt;
      r_instr      <= w_instr_nxt;
      r_fetch_pc   <= w_fetch_pc_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
    end
  end

  assign IF_success = r_if_success;
  assign instr      = r_instr;
  assign fetch_pc   = r_fetch_pc;
  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: cold miss, warm hits, stall, rdy freeze,
// redirect during a miss, fill colliding with redirect, aliasing eviction
// and reset during an outstanding miss. Inputs change and outputs are
// sampled 1 time unit after each rising edge.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        stall;
  logic        jump_wrong;
  logic [31:0] jump_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_instr;
  logic        IF_success;
  logic [31:0] instr;
  logic [31:0] fetch_pc;

  int n_pass  = 0;
  int n_total = 0;

  // Instruction words used as memory contents
  localparam logic [31:0] D0   = 32'h00500093;
  localparam logic [31:0] D4   = 32'h00a00113;
  localparam logic [31:0] D8   = 32'h002081b3;
  localparam logic [31:0] D12  = 32'h40110233;
  localparam logic [31:0] D40  = 32'h12345678;
  localparam logic [31:0] D44  = 32'hdeadbeef;
  localparam logic [31:0] D100 = 32'hcafe0100;

  always #5 clk = ~clk;

  ifetch_unit #(
    .ICACHE_LINES (64),
    .IDX_W        (6),
    .RESET_PC     (32'h0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .stall      (stall),
    .jump_wrong (jump_wrong),
    .jump_pc    (jump_pc),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_done   (mem_done),
    .mem_instr  (mem_instr),
    .IF_success (IF_success),
    .instr      (instr),
    .fetch_pc   (fetch_pc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_issue(input string tag, input logic [31:0] pc, input logic [31:0] data);
    check({tag, "_if"},  {31'b0, IF_success}, 32'd1);
    check({tag, "_pc"},  fetch_pc, pc);
    check({tag, "_ins"}, instr, data);
  endtask

  // Waits (bounded) for a memory request and checks its address.
  task automatic wait_req(input string tag, input logic [31:0] addr);
    int k = 0;
    while (!mem_req && k < 8) begin
      step();
      k++;
    end
    check({tag, "_req"},  {31'b0, mem_req}, 32'd1);
    check({tag, "_addr"}, mem_addr, addr);
    check({tag, "_quiet"}, {31'b0, IF_success}, 32'd0);
  endtask

  // Answers the outstanding request after one extra wait cycle.
  task automatic serve(input string tag, input logic [31:0] data);
    step();
    check({tag, "_hold"}, {31'b0, mem_req}, 32'd1);
    mem_done  = 1'b1;
    mem_instr = data;
    step();
    mem_done  = 1'b0;
    mem_instr = 32'h0;
    check({tag, "_drop"}, {31'b0, mem_req}, 32'd0);
    check({tag, "_noif"}, {31'b0, IF_success}, 32'd0);
  endtask

  task automatic redirect(input logic [31:0] pc);
    jump_wrong = 1'b1;
    jump_pc    = pc;
    step();
    jump_wrong = 1'b0;
    jump_pc    = 32'h0;
  endtask

  initial begin
    logic [31:0] warm [4];
    warm[0] = D0; warm[1] = D4; warm[2] = D8; warm[3] = D12;

    rst = 1'b1; rdy = 1'b1; stall = 1'b0; jump_wrong = 1'b0; jump_pc = 32'h0;
    mem_done = 1'b0; mem_instr = 32'h0;
    step();
    step();

    // Reset values
    check("rst_if",   {31'b0, IF_success}, 32'd0);
    check("rst_ins",  instr, 32'h0);
    check("rst_pc",   fetch_pc, 32'h0);
    check("rst_req",  {31'b0, mem_req}, 32'd0);
    check("rst_addr", mem_addr, 32'h0);

    // Cold miss at RESET_PC, mem_done after 3 cycles
    rst = 1'b0;
    step();
    check("cold_req",  {31'b0, mem_req}, 32'd1);
    check("cold_addr", mem_addr, 32'h0);
    step();
    step();
    check("cold_hold", {31'b0, mem_req}, 32'd1);
    mem_done = 1'b1; mem_instr = D0;
    step();
    mem_done = 1'b0; mem_instr = 32'h0;
    check("cold_drop", {31'b0, mem_req}, 32'd0);
    check("cold_noif", {31'b0, IF_success}, 32'd0);
    step();
    check_issue("cold_issue", 32'h0, D0);
    step();
    wait_req("miss4", 32'h4);

    // Fill 4, 8, 12 through the miss path
    serve("fill4", D4);
    step();
    check_issue("iss4", 32'h4, D4);
    step();
    wait_req("miss8", 32'h8);
    serve("fill8", D8);
    step();
    check_issue("iss8", 32'h8, D8);
    step();
    wait_req("miss12", 32'hc);
    serve("fill12", D12);
    step();
    check_issue("iss12", 32'hc, D12);
    step();
    wait_req("miss16", 32'h10);

    // Warm hits: redirect to 0, four back-to-back issues with no request
    redirect(32'h0);
    check("warm_redir_req", {31'b0, mem_req}, 32'd0);
    check("warm_redir_if",  {31'b0, IF_success}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_issue("warm", 32'(4 * i), warm[i]);
      check("warm_noreq", {31'b0, mem_req}, 32'd0);
    end
    step();
    wait_req("warm_miss16", 32'h10);

    // Stall for 5 cycles mid-stream
    redirect(32'h0);
    step();
    check_issue("st_iss0", 32'h0, D0);
    step();
    check_issue("st_iss4", 32'h4, D4);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_if",  {31'b0, IF_success}, 32'd0);
      check("stall_req", {31'b0, mem_req}, 32'd0);
    end
    stall = 1'b0;
    step();
    check_issue("st_iss8", 32'h8, D8);

    // rdy low for 4 cycles: no issue, nothing advances
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rdy_if", {31'b0, IF_success}, 32'd0);
      check("rdy_pc", fetch_pc, 32'h8);
    end
    rdy = 1'b1;
    step();
    check_issue("rdy_iss12", 32'hc, D12);
    step();
    wait_req("rdy_miss16", 32'h10);

    // Redirect while waiting on 0x100
    redirect(32'h100);
    check("r100_drop", {31'b0, mem_req}, 32'd0);
    step();
    wait_req("r100_miss", 32'h100);
    step();
    check("r100_hold", {31'b0, mem_req}, 32'd1);
    redirect(32'h40);
    check("r40_drop", {31'b0, mem_req}, 32'd0);
    check("r40_noif", {31'b0, IF_success}, 32'd0);
    step();
    wait_req("r40_miss", 32'h40);
    serve("fill40", D40);
    step();
    check_issue("iss40", 32'h40, D40);
    step();
    wait_req("miss44", 32'h44);

    // Fill and redirect in the same cycle: word cached but not issued
    mem_done = 1'b1; mem_instr = D44;
    redirect(32'h200);
    mem_done = 1'b0; mem_instr = 32'h0;
    check("coll_drop", {31'b0, mem_req}, 32'd0);
    check("coll_noif", {31'b0, IF_success}, 32'd0);
    step();
    wait_req("coll_miss200", 32'h200);
    redirect(32'h44);
    check("coll_redir_req", {31'b0, mem_req}, 32'd0);
    step();
    check_issue("coll_iss44", 32'h44, D44);

    // Aliasing: 0x0 and 0x100 share line 0
    redirect(32'h0);
    check("al_noif", {31'b0, IF_success}, 32'd0);
    check("al_req",  {31'b0, mem_req}, 32'd0);
    step();
    check_issue("al_iss0", 32'h0, D0);
    redirect(32'h100);
    check("al_no4", {31'b0, IF_success}, 32'd0);
    step();
    wait_req("al_miss100", 32'h100);
    serve("al_fill100", D100);
    step();
    check_issue("al_iss100", 32'h100, D100);
    redirect(32'h0);
    check("al_redir_req", {31'b0, mem_req}, 32'd0);
    step();
    check("al_re0_req",  {31'b0, mem_req}, 32'd1);
    check("al_re0_addr", mem_addr, 32'h0);
    check("al_re0_noif", {31'b0, IF_success}, 32'd0);

    // Reset while waiting on memory: request drops without a clock edge
    #1;
    rst = 1'b1;
    #1;
    check("amid_req",  {31'b0, mem_req}, 32'd0);
    check("amid_addr", mem_addr, 32'h0);
    check("amid_pc",   fetch_pc, 32'h0);
    step();
    step();
    // Late mem_done right after reset release lands in IDLE and is ignored
    rst = 1'b0;
    mem_done = 1'b1; mem_instr = 32'hbad0bad0;
    step();
    mem_done = 1'b0; mem_instr = 32'h0;
    check("late_req",  {31'b0, mem_req}, 32'd1);
    check("late_addr", mem_addr, 32'h0);
    check("late_noif", {31'b0, IF_success}, 32'd0);
    serve("post_fill0", D0);
    step();
    check_issue("post_iss0", 32'h0, D0);
    // Line for 4 was valid before reset; it must miss now
    step();
    wait_req("post_miss4", 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
